matrix_multiply_mac_datapath: RTL
=================================

# matrix_multiply_mac_datapath

Arithmetic datapath that sits directly downstream of `matrix_multiply_control`. It computes y = A·x for a MATRIX_SIZE × ROW_COL_SIZE signed matrix A and a ROW_COL_SIZE vector x. It consumes the controller's `start`/`busy`/`col_done` strobes together with one operand pair per cycle, and accumulates one dot product per matrix row. It stores each row result in an internal result memory and streams the results out under the controller's `read_busy`/`output_select` sequencing.

## Interface
- DATA_WIDTH, 8: operand width, signed two's complement
- ROW_COL_SIZE, 16: elements per row (dot-product length)
- MATRIX_SIZE, 16: number of rows and number of results
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(ROW_COL_SIZE): accumulator and result width, signed
- MATRIX_COUNTER_SIZE, $clog2(MATRIX_SIZE): `output_select` width
- clk  in  1  clock; all logic is rising-edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  controller start pulse; marks the column-0 operand cycle of row 0
- busy  in  1  controller busy
- col_done  in  1  controller one-cycle pulse, high the cycle after a row's last operand
- a_data  in  DATA_WIDTH  element A[row_select][col_select]
- b_data  in  DATA_WIDTH  element x[col_select]
- read_busy  in  1  controller read-active
- output_select  in  MATRIX_COUNTER_SIZE  result index to read
- result_data  out  ACC_WIDTH  registered read data
- result_valid  out  1  result_data is valid this cycle
- result_last  out  1  with result_valid; the beat is index MATRIX_SIZE-1
- results_ready  out  1  all MATRIX_SIZE results have been written since the last start

## Operation
- mac_en = start || busy. Operands are sampled on every cycle where mac_en is high.
- Stage 1 (multiply): on each edge, prod_reg <= sign-extended a_data*b_data (2*DATA_WIDTH bits) and prod_valid <= mac_en.
- Stage 2 (accumulate/commit): on each edge where prod_valid is high:
  - col_done=0: acc <= acc + prod_reg
  - col_done=1: mem[wr_ptr] <= acc + prod_reg, then acc <= 0, wr_ptr <= wr_ptr+1
- A commit is suppressed once wr_ptr has reached MATRIX_SIZE. wr_ptr is $clog2(MATRIX_SIZE)+1 bits wide.
- start has priority: it sets acc <= 0, wr_ptr <= 0 and results_ready <= 0. Stage 1 still captures the start-cycle product.
- After the last row, the controller keeps busy high for several extra cycles. The products from those cycles go into acc but are never committed. The next start discards them.
- results_ready <= 1 on the edge that commits index MATRIX_SIZE-1. It holds until the next start or reset.
- Arithmetic is full-precision signed. ACC_WIDTH is sized so no overflow is possible. There is no saturation.
- Read side: on each edge, result_valid <= read_busy. When read_busy is high, result_data <= mem[output_select] and result_last <= (output_select == MATRIX_SIZE-1). When read_busy is low, result_data holds its value and result_last <= 0.
- The memory is read-first. If a commit and a read hit the same index in the same cycle, the read returns the old contents.
- Reading an index before it has been committed returns stale memory contents. This is legal and not flagged.

## Timing
- Reset values:
  - result_data=0, result_valid=0, result_last=0, results_ready=0
  - acc=0, prod_reg=0, prod_valid=0, wr_ptr=0
  - Memory contents are not reset.
- Operand-to-product latency is 1 cycle. The row result is committed on the edge that ends the col_done cycle, i.e. 2 edges after the row's last operand is presented.
- Row r commits ROW_COL_SIZE cycles after row r-1. The first commit occurs ROW_COL_SIZE+1 edges after the start cycle.
- Read latency is 1 cycle: output_select sampled at edge n appears on result_data at cycle n+1. A full read yields exactly MATRIX_SIZE consecutive result_valid beats, with indices 0..MATRIX_SIZE-1 in order.
- Reset mid-operation: all state returns to reset values on the next edge. Operand and col_done inputs seen while resetn=0 are ignored.
- start while busy (restart): the in-flight row is abandoned and the new sequence begins cleanly from index 0.

## Test plan
- ROW_COL_SIZE=4, MATRIX_SIZE=4, DATA_WIDTH=8, A=identity, x=[3,-5,7,1] driven with controller timing -> results [3,-5,7,1], results_ready rises on the 4th commit, read gives 4 valid beats with result_last on beat 4.
- All a=-128, b=-128 -> every result is 65536 (18-bit signed), no wrap. Mixed a=127, b=-128 -> every result is -65024.
- Read issued when read_busy rises -> result_valid first high exactly 1 cycle later, indices 0,1,2,3, then result_valid=0.
- Restart: start pulsed mid-row 2 with new A -> results_ready drops, final results reflect only the new A, no residue from the partial accumulator.
- resetn low for 1 cycle mid-row 1 -> all outputs 0 on the next cycle, a subsequent start produces correct results.
- Read index 2 on the same cycle as its commit -> old value returned; a reread afterwards returns the new value.

Source files
------------

// File: rtl/matrix_multiply_mac_datapath_if.sv
// Operand, strobe and result-stream signals between the matrix-multiply
// controller (master) and the MAC datapath (slave).
interface matrix_multiply_mac_datapath_if #(
   parameter int DATA_WIDTH          = 8,
   parameter int ACC_WIDTH           = 20,
   parameter int MATRIX_COUNTER_SIZE = 4
);
   logic                           start;
   logic                           busy;
   logic                           col_done;
   logic [DATA_WIDTH-1:0]          a_data;
   logic [DATA_WIDTH-1:0]          b_data;
   logic                           read_busy;
   logic [MATRIX_COUNTER_SIZE-1:0] output_select;
   logic [ACC_WIDTH-1:0]           result_data;
   logic                           result_valid;
   logic                           result_last;
   logic                           results_ready;

   modport master (
      output start, busy, col_done, a_data, b_data, read_busy, output_select,
      input  result_data, result_valid, result_last, results_ready
   );

   modport slave (
      input  start, busy, col_done, a_data, b_data, read_busy, output_select,
      output result_data, result_valid, result_last, results_ready
   );
endinterface

// File: rtl/matrix_multiply_mac_datapath.sv
// MAC datapath for y = A*x: one signed multiply per cycle, one accumulated dot
// product per matrix row, results stored in a small read-first memory and
// streamed out under the controller's read sequencing.
module matrix_multiply_mac_datapath #(
   parameter int DATA_WIDTH          = 8,
   parameter int ROW_COL_SIZE        = 16,
   parameter int MATRIX_SIZE         = 16,
   parameter int ACC_WIDTH           = 2*DATA_WIDTH + $clog2(ROW_COL_SIZE),
   parameter int MATRIX_COUNTER_SIZE = $clog2(MATRIX_SIZE)
) (
   input logic                            clk,
   input logic                            resetn,
   matrix_multiply_mac_datapath_if.slave  bus
);

   localparam int PROD_W = 2*DATA_WIDTH;
   localparam int EXT_W  = ACC_WIDTH - PROD_W;
   // One extra bit so the pointer can sit at MATRIX_SIZE and block further commits.
   localparam int PTR_W  = $clog2(MATRIX_SIZE) + 1;

   localparam logic [PTR_W-1:0]               LP_PTR_FULL = PTR_W'(MATRIX_SIZE);
   localparam logic [PTR_W-1:0]               LP_PTR_LAST = PTR_W'(MATRIX_SIZE-1);
   localparam logic [MATRIX_COUNTER_SIZE-1:0] LP_SEL_LAST = MATRIX_COUNTER_SIZE'(MATRIX_SIZE-1);

   logic [PROD_W-1:0]    r_prod;
   logic                 r_prod_valid;
   logic [ACC_WIDTH-1:0] r_acc;
   logic [PTR_W-1:0]     r_wr_ptr;
   logic                 r_results_ready;
   logic [ACC_WIDTH-1:0] r_mem [MATRIX_SIZE];
   logic [ACC_WIDTH-1:0] r_result_data;
   logic                 r_result_valid;
   logic                 r_result_last;

   logic                 w_mac_en;
   logic [PROD_W-1:0]    w_a_ext;
   logic [PROD_W-1:0]    w_b_ext;
   logic [PROD_W-1:0]    w_prod;
   logic [ACC_WIDTH-1:0] w_prod_ext;
   logic [ACC_WIDTH-1:0] w_sum;
   logic                 w_ptr_ok;
   logic                 w_commit;

   assign w_mac_en = bus.start | bus.busy;

   // Both operands are widened to the full product width first, so the low
   // PROD_W bits of the multiply are the exact signed product.
   assign w_a_ext = {{DATA_WIDTH{bus.a_data[DATA_WIDTH-1]}}, bus.a_data};
   assign w_b_ext = {{DATA_WIDTH{bus.b_data[DATA_WIDTH-1]}}, bus.b_data};
   assign w_prod  = w_a_ext * w_b_ext;

   assign w_prod_ext = {{EXT_W{r_prod[PROD_W-1]}}, r_prod};
   assign w_sum      = r_acc + w_prod_ext;
   assign w_ptr_ok   = (r_wr_ptr < LP_PTR_FULL);
   assign w_commit   = resetn && !bus.start && r_prod_valid && bus.col_done && w_ptr_ok;

   // Stage 1: register the product of the operands presented this cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_prod       <= '0;
         r_prod_valid <= 1'b0;
      end else begin
         r_prod       <= w_prod;
         r_prod_valid <= w_mac_en;
      end
   end

   // Stage 2: accumulate the row; on col_done close it out and advance the write pointer.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_acc           <= '0;
         r_wr_ptr        <= '0;
         r_results_ready <= 1'b0;
      end else if (bus.start) begin
         r_acc           <= '0;
         r_wr_ptr        <= '0;
         r_results_ready <= 1'b0;
      end else if (r_prod_valid) begin
         if (bus.col_done) begin
            r_acc <= '0;
            if (w_ptr_ok) begin
               r_wr_ptr <= r_wr_ptr + PTR_W'(1);
               if (r_wr_ptr == LP_PTR_LAST) begin
                  r_results_ready <= 1'b1;
               end
            end
         end else begin
            r_acc <= w_sum;
         end
      end
   end

   // Result memory write port; contents deliberately have no reset.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         r_mem[r_wr_ptr[PTR_W-2:0]] <= w_sum;
      end
   end

   // Registered read port; a same-cycle commit to the read index is not visible yet.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_result_data  <= '0;
         r_result_valid <= 1'b0;
         r_result_last  <= 1'b0;
      end else begin
         r_result_valid <= bus.read_busy;
         if (bus.read_busy) begin
            r_result_data <= r_mem[bus.output_select];
            r_result_last <= (bus.output_select == LP_SEL_LAST);
         end else begin
            r_result_last <= 1'b0;
         end
      end
   end

   assign bus.result_data   = r_result_data;
   assign bus.result_valid  = r_result_valid;
   assign bus.result_last   = r_result_last;
   assign bus.results_ready = r_results_ready;

endmodule
